// File: rtl/imem_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_ctrl_pkg : shared sizes and FSM encoding for the imem loader    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package imem_ctrl_pkg;

  localparam int IMEM_DEPTH  = 16;
  localparam int IMEM_ADDR_W = 6;
  localparam int IMEM_WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } imem_state_t;

endpackage
`default_nettype wire

// File: rtl/imem_byte_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_byte_packer : big-endian byte-to-word shift register            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module imem_byte_packer
  import imem_ctrl_pkg::*;
#(
  parameter int WORD_W = IMEM_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              full
);

  logic [WORD_W-1:0] r_word;
  logic [1:0]        r_byte_cnt;

  // clear wins over accept so an aborted partial word never survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word     <= '0;
      r_byte_cnt <= 2'd0;
    end else if (clear) begin
      r_word     <= '0;
      r_byte_cnt <= 2'd0;
    end else if (accept) begin
      r_word     <= {r_word[WORD_W-9:0], byte_in};
      r_byte_cnt <= r_byte_cnt + 2'd1;
    end
  end

  assign word = r_word;
  assign full = (r_byte_cnt == 2'd3);

endmodule
`default_nettype wire

// File: rtl/imem_load_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_load_ctrl : instruction memory arbiter and byte-stream loader   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module imem_load_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int WORD_W = IMEM_WORD_W,
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [4:0]        load_len,
  input  logic              load_abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              load_done,
  output logic              err
);

  localparam int               IDX_W     = ADDR_W - 2;
  localparam logic [4:0]       c_depth   = 5'(DEPTH);
  localparam logic [IDX_W-1:0] c_idx_one = IDX_W'(1);

  imem_state_t       r_state, w_next_state;
  logic [4:0]        r_len;
  logic [IDX_W-1:0]  r_word_idx;
  logic              r_err;
  logic              w_len_ok, w_accept, w_clear, w_full, w_last, w_start_ok;
  logic [WORD_W-1:0] w_word;

  assign w_len_ok   = (load_len != 5'd0) && (load_len <= c_depth);
  assign w_start_ok = (r_state == ST_IDLE) && load_start && w_len_ok;
  assign w_accept   = (r_state == ST_LOAD) && byte_valid && !load_abort;
  assign w_clear    = (r_state == ST_IDLE) || load_abort;
  assign w_last     = (5'(r_word_idx) == (r_len - 5'd1));

  imem_byte_packer #(.WORD_W(WORD_W)) u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_clear),
    .accept  (w_accept),
    .byte_in (byte_data),
    .word    (w_word),
    .full    (w_full)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_ok) w_next_state = ST_LOAD;
      ST_LOAD: begin
        if (load_abort)             w_next_state = ST_IDLE;
        else if (w_accept && w_full) w_next_state = ST_WRITE;
      end
      ST_WRITE: begin
        if (load_abort)  w_next_state = ST_IDLE;
        else if (w_last) w_next_state = ST_DONE;
        else             w_next_state = ST_LOAD;
      end
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // err covers both a rejected start and an abort of an active load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len      <= 5'd0;
      r_word_idx <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= ((r_state == ST_IDLE) && load_start && !w_len_ok) ||
               (((r_state == ST_LOAD) || (r_state == ST_WRITE)) && load_abort);
      if (w_start_ok) begin
        r_len      <= load_len;
        r_word_idx <= '0;
      end else if ((r_state == ST_WRITE) && !load_abort && !w_last) begin
        r_word_idx <= r_word_idx + c_idx_one;
      end
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign cpu_hold   = (r_state != ST_IDLE);
  assign byte_ready = (r_state == ST_LOAD);
  assign mem_we     = (r_state == ST_WRITE);
  assign load_done  = (r_state == ST_DONE);
  assign err        = r_err;
  assign mem_wdata  = (r_state == ST_WRITE) ? w_word : '0;
  assign mem_addr   = (r_state == ST_IDLE) ? cpu_addr : {r_word_idx, 2'b00};

endmodule
`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imem_load_ctrl : directed self-checking bench for imem_load_ctrl  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_imem_load_ctrl;
  import imem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic [4:0]  load_len = 5'd0;
  logic        load_abort = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready;
  logic [5:0]  cpu_addr = 6'h14;
  logic        cpu_hold;
  logic [5:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        busy, load_done, err;

  always #5 clk = ~clk;

  imem_load_ctrl dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_len(load_len),
    .load_abort(load_abort), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .cpu_addr(cpu_addr), .cpu_hold(cpu_hold),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .busy(busy),
    .load_done(load_done), .err(err)
  );

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;
  bit track = 1'b0;
  logic [5:0]  wr_a[$];
  logic [31:0] wr_d[$];
  int done_cnt = 0;
  int hold_drop = 0;
  logic [31:0] exp_w[16];

  // write/pulse monitor on the falling edge, away from state updates
  always @(negedge clk) begin
    if (mem_we) begin
      wr_a.push_back(mem_addr);
      wr_d.push_back(mem_wdata);
    end
    if (load_done) done_cnt++;
    if (track && !cpu_hold) hold_drop++;
  end

  typedef struct {
    logic       ls;
    logic [4:0] len;
    logic       ab;
    logic [5:0] ca;
    logic       e_busy;
    logic       e_err;
    logic [5:0] e_addr;
  } vec_t;

  vec_t tv[7];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start_load(input logic [4:0] len);
    load_start = 1'b1;
    load_len   = len;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (!byte_ready && t < 10) begin
      tick();
      t++;
    end
    if (!byte_ready) chk("byte_ready_timeout", 32'(byte_ready), 32'd1);
    tick();
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int j = 3; j >= 0; j--) send_byte(w[j*8 +: 8]);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!load_done && n < 40) begin
      tick();
      n++;
    end
    chk("load_done_seen", 32'(load_done), 32'd1);
  endtask

  task automatic check_writes(input int base, input int n);
    chk("write_count", 32'(wr_a.size() - base), 32'(n));
    for (int k = 0; k < n; k++) begin
      if (base + k < wr_a.size()) begin
        chk("write_addr", 32'(wr_a[base+k]), 32'(k * 4));
        chk("write_data", wr_d[base+k], exp_w[k]);
      end
    end
  endtask

  function automatic logic [31:0] gen_word(input int i);
    return {i[7:0], 8'hA5 ^ i[7:0], i[3:0], 4'h9, 8'hC3};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bw, bd, bh, t0;

    // {load_start, len, abort, cpu_addr, exp busy, exp err, exp mem_addr}
    tv[0] = '{1'b0, 5'd0,  1'b0, 6'h14, 1'b0, 1'b0, 6'h14};
    tv[1] = '{1'b1, 5'd0,  1'b0, 6'h14, 1'b0, 1'b1, 6'h14};
    tv[2] = '{1'b0, 5'd0,  1'b0, 6'h20, 1'b0, 1'b0, 6'h20};
    tv[3] = '{1'b1, 5'd17, 1'b0, 6'h20, 1'b0, 1'b1, 6'h20};
    tv[4] = '{1'b0, 5'd0,  1'b0, 6'h3C, 1'b0, 1'b0, 6'h3C};
    tv[5] = '{1'b0, 5'd0,  1'b1, 6'h08, 1'b0, 1'b0, 6'h08};
    tv[6] = '{1'b1, 5'd31, 1'b0, 6'h04, 1'b0, 1'b1, 6'h04};

    // reset state
    cpu_addr = 6'h14;
    tick();
    tick();
    chk("rst_mem_addr", 32'(mem_addr), 32'h14);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick();

    // idle passthrough, illegal lengths, abort in idle
    for (int i = 0; i < 7; i++) begin
      load_start = tv[i].ls;
      load_len   = tv[i].len;
      load_abort = tv[i].ab;
      cpu_addr   = tv[i].ca;
      tick();
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tv[i].e_busy));
      chk($sformatf("vec%0d_hold", i), 32'(cpu_hold), 32'(tv[i].e_busy));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(tv[i].e_err));
      chk($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(tv[i].e_addr));
    end
    load_start = 1'b0;
    load_abort = 1'b0;
    tick();

    exp_w[0] = 32'h20080017;
    exp_w[1] = 32'h2109002d;

    // back-to-back two-word load
    bw = wr_a.size(); bd = done_cnt; bh = hold_drop;
    start_load(5'd2);
    t0 = cyc;
    track = 1'b1;
    send_word(exp_w[0]);
    send_word(exp_w[1]);
    byte_valid = 1'b0;
    wait_done();
    chk("done_latency", 32'(cyc - t0 + 1), 32'd11);
    chk("done_hold", 32'(cpu_hold), 32'd1);
    track = 1'b0;
    tick();
    chk("post_done_busy", 32'(busy), 32'd0);
    chk("post_done_hold", 32'(cpu_hold), 32'd0);
    chk("done_pulses", 32'(done_cnt - bd), 32'd1);
    chk("hold_gaps", 32'(hold_drop - bh), 32'd0);
    check_writes(bw, 2);

    // gapped bytes, byte offered during WRITE
    bw = wr_a.size();
    start_load(5'd2);
    for (int j = 3; j >= 0; j--) begin
      byte_valid = 1'b0;
      tick();
      tick();
      send_byte(exp_w[0][j*8 +: 8]);
    end
    byte_valid = 1'b1;
    byte_data  = 8'h21;
    chk("write_ready", 32'(byte_ready), 32'd0);
    chk("write_we", 32'(mem_we), 32'd1);
    chk("write_wdata", mem_wdata, exp_w[0]);
    send_byte(8'h21);
    for (int j = 2; j >= 0; j--) begin
      byte_valid = 1'b0;
      tick();
      send_byte(exp_w[1][j*8 +: 8]);
    end
    byte_valid = 1'b0;
    wait_done();
    tick();
    check_writes(bw, 2);

    // load_start while busy is ignored
    bw = wr_a.size();
    start_load(5'd2);
    send_byte(8'h20);
    send_byte(8'h08);
    byte_valid = 1'b0;
    load_start = 1'b1; load_len = 5'd0;
    tick();
    chk("busy_start0_err", 32'(err), 32'd0);
    load_len = 5'd1;
    tick();
    load_start = 1'b0;
    chk("busy_start1_err", 32'(err), 32'd0);
    chk("busy_start1_busy", 32'(busy), 32'd1);
    send_byte(8'h00);
    send_byte(8'h17);
    send_word(exp_w[1]);
    byte_valid = 1'b0;
    wait_done();
    tick();
    check_writes(bw, 2);

    // abort in LOAD after six bytes, with a same-cycle byte
    for (int i = 0; i < 4; i++) exp_w[i] = gen_word(i + 40);
    bw = wr_a.size(); bd = done_cnt;
    start_load(5'd4);
    send_word(exp_w[0]);
    send_byte(exp_w[1][31:24]);
    send_byte(exp_w[1][23:16]);
    load_abort = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h77;
    tick();
    load_abort = 1'b0;
    byte_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_err", 32'(err), 32'd1);
    chk("abort_hold", 32'(cpu_hold), 32'd0);
    cpu_addr = 6'h28;
    #1;
    chk("abort_mem_addr", 32'(mem_addr), 32'h28);
    tick();
    chk("abort_err_clear", 32'(err), 32'd0);
    chk("abort_no_done", 32'(done_cnt - bd), 32'd0);
    check_writes(bw, 1);

    // abort in WRITE: write still happens that cycle
    bw = wr_a.size(); bd = done_cnt;
    start_load(5'd2);
    send_word(exp_w[0]);
    load_abort = 1'b1;
    chk("wabort_we", 32'(mem_we), 32'd1);
    tick();
    load_abort = 1'b0;
    chk("wabort_busy", 32'(busy), 32'd0);
    chk("wabort_err", 32'(err), 32'd1);
    tick();
    chk("wabort_no_done", 32'(done_cnt - bd), 32'd0);
    check_writes(bw, 1);

    // full sixteen-word load
    for (int i = 0; i < 16; i++) exp_w[i] = gen_word(i);
    bw = wr_a.size();
    start_load(5'd16);
    for (int i = 0; i < 16; i++) send_word(exp_w[i]);
    byte_valid = 1'b0;
    wait_done();
    for (int i = 0; i < 4; i++) tick();
    check_writes(bw, 16);
    if (wr_a.size() > 0) chk("last_addr", 32'(wr_a[wr_a.size()-1]), 32'h3C);

    // reset in the middle of word 5
    bw = wr_a.size();
    start_load(5'd16);
    for (int i = 0; i < 5; i++) send_word(exp_w[i]);
    send_byte(exp_w[5][31:24]);
    send_byte(exp_w[5][23:16]);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we", 32'(mem_we), 32'd0);
    chk("rst_mid_hold", 32'(cpu_hold), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ready", 32'(byte_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    byte_valid = 1'b0;
    chk("rst_mid_idle", 32'(busy), 32'd0);
    chk("rst_mid_err", 32'(err), 32'd0);
    check_writes(bw, 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
